path_node_fifo: RTL and testbench
=================================

// Module: path_node_fifo
// PURPOSE
//  Memory-mapped path buffer on the data-memory store bus of the single-cycle RISC-V core.
//  Snoops CPU stores to PATH_ADDR, queues planned node IDs, and hands them one at a time
//  to the downstream motion/line-follow controller over a valid/ready handshake.
//  Control and status words are mapped at CTRL_ADDR / STAT_ADDR so firmware can start,
//  flush and poll the path.
// PARAMETERS
//  DATA_WIDTH  32            store data / status read width
//  ADDR_WIDTH  32            store address width
//  NODE_W      5             node ID width
//  DEPTH       16            FIFO entries, power of two
//  PATH_ADDR   32'h0200_0008 store here = push wr_data[NODE_W-1:0]
//  CTRL_ADDR   32'h0200_000C store here: bit0 start, bit1 flush
//  STAT_ADDR   32'h0200_0010 status read address
// PORTS
//  clk          in   1           clock, all state on rising edge
//  reset        in   1           synchronous, active-low reset
//  wr_en        in   1           CPU store strobe (same as data memory)
//  wr_addr      in   ADDR_WIDTH  store/load address
//  wr_data      in   DATA_WIDTH  store data
//  stat_hit     out  1           comb: wr_addr==STAT_ADDR (load mux select)
//  stat_rd_data out  DATA_WIDTH  comb status word, see below
//  node_valid   out  1           head node available to consumer
//  node_ready   in   1           consumer accepts head this cycle
//  node_id      out  NODE_W      head node ID
//  path_done    out  1           high while state==DONE
//  overflow     out  1           sticky: push dropped while full
// BEHAVIOUR
//  Reset (reset==0 at posedge): rd_ptr=wr_ptr=count=0, state=IDLE, overflow=0; all FIFO
//   entries cleared to 0; node_valid=0, node_id=0, path_done=0. Mid-operation reset
//   discards the queue; a handshake in that cycle is lost.
//  CNT_W=$clog2(DEPTH)+1; count ranges 0..DEPTH; full=(count==DEPTH), empty=(count==0).
//  push = wr_en && wr_addr==PATH_ADDR (full 32-bit compare, any store width).
//  pop  = node_valid && node_ready.
//  Push while full: data dropped, overflow<=1 (sticky until flush/reset).
//  Push+pop same cycle: both performed, count unchanged; legal even when full
//   (pop frees slot first) and accepted in any state except DONE.
//  Pointers wrap modulo DEPTH; no other wrap handling.
//  node_id = fifo[rd_ptr] (comb from head); node_valid = (state==RUN) && !empty.
//  Latency: a push at edge N into an empty FIFO in RUN gives node_valid=1 after edge N.
//  node_id must hold stable while node_valid && !node_ready.
//  FSM (2-bit): IDLE=0, LOAD=1, RUN=2, DONE=3.
//   IDLE: push -> LOAD. start with empty FIFO ignored.
//   LOAD: start -> RUN.
//   RUN : pop leaving count==0 with no push in that cycle -> DONE.
//   DONE: pushes ignored (no overflow); path_done=1; start -> IDLE.
//   Flush (CTRL bit1) from any state: pointers/count/overflow cleared, -> IDLE;
//   flush beats start and beats a push/pop in the same cycle.
//  ctrl write = wr_en && wr_addr==CTRL_ADDR; bits other than 0/1 ignored.
//  stat_rd_data: [CNT_W-1:0] count, [9:8] state, [12] full, [13] empty, [14] overflow,
//   other bits 0. Reflects current registered values (pre-edge).
// TESTING
//  1. Reset low 2 cycles -> count=0, state=IDLE, node_valid=0, stat_rd_data=32'h0000_2000.
//  2. Store 3,7,12 to PATH_ADDR, CTRL=1, node_ready=1 -> node_id 3,7,12 on consecutive
//     cycles, then state=DONE, path_done=1.
//  3. 17 pushes (0..16) in LOAD -> count=16, full=1, overflow=1; drain yields 0..15 only.
//  4. RUN, count=1, push 9 with node_ready=1 same cycle -> count stays 1, no DONE,
//     next node_id=9.
//  5. node_ready=0 for 5 cycles while node_valid -> node_id stable, count unchanged.
//  6. Mid-RUN store CTRL=3 -> state=IDLE, count=0, overflow=0 next cycle.

Source files
------------

// File: rtl/path_node_fifo.sv
// path_node_fifo: store-snooping path node queue with start/flush control and valid/ready output
module path_node_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NODE_W = 5,
  parameter int DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] PATH_ADDR = 32'h0200_0008,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR = 32'h0200_000C,
  parameter logic [ADDR_WIDTH-1:0] STAT_ADDR = 32'h0200_0010
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  stat_hit,
  output logic [DATA_WIDTH-1:0] stat_rd_data,
  output logic                  node_valid,
  input  logic                  node_ready,
  output logic [NODE_W-1:0]     node_id,
  output logic                  path_done,
  output logic                  overflow
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0] state, state_nx;
  logic [NODE_W-1:0] fifo [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic full, empty, push_hit, ctrl_wr, start, flush, pop, do_push, ovf_set;
  logic unused_data;
  assign unused_data = &{1'b0, wr_data[DATA_WIDTH-1:NODE_W]};
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign push_hit = wr_en && wr_addr == PATH_ADDR;
  assign ctrl_wr = wr_en && wr_addr == CTRL_ADDR;
  assign start = ctrl_wr && wr_data[0];
  assign flush = ctrl_wr && wr_data[1];
  assign pop = node_valid && node_ready;
  assign do_push = push_hit && state != DONE && (!full || pop);
  assign ovf_set = push_hit && state != DONE && full && !pop;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = push_hit ? LOAD : IDLE;
      LOAD: state_nx = start ? RUN : LOAD;
      RUN:  state_nx = (pop && count == CNT_W'(1) && !do_push) ? DONE : RUN;
      DONE: state_nx = start ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end
  always_comb begin
    node_valid = state == RUN && !empty;
    path_done = state == DONE;
    node_id = fifo[rd_ptr];
    stat_hit = wr_addr == STAT_ADDR;
    stat_rd_data = '0;
    stat_rd_data[CNT_W-1:0] = count;
    stat_rd_data[9:8] = state;
    stat_rd_data[12] = full;
    stat_rd_data[13] = empty;
    stat_rd_data[14] = overflow;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) fifo[wr_ptr] <= wr_data[NODE_W-1:0];
      wr_ptr <= do_push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      count <= count + CNT_W'(do_push) - CNT_W'(pop);
      overflow <= overflow || ovf_set;
    end
  end
endmodule

// File: tb/tb_path_node_fifo.sv
// tb_path_node_fifo: directed self-checking bench for path_node_fifo
module tb_path_node_fifo;
  localparam logic [31:0] PA = 32'h0200_0008, CA = 32'h0200_000C, SA = 32'h0200_0010;
  logic clk = 1'b0, reset = 1'b0, wr_en = 1'b0, node_ready = 1'b0;
  logic [31:0] wr_addr = SA, wr_data = '0;
  logic stat_hit, node_valid, path_done, overflow;
  logic [31:0] stat_rd_data;
  logic [4:0] node_id;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  path_node_fifo dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .stat_hit(stat_hit), .stat_rd_data(stat_rd_data), .node_valid(node_valid),
    .node_ready(node_ready), .node_id(node_id), .path_done(path_done), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic en, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    wr_en = en;
    wr_addr = a;
    wr_data = d;
    node_ready = rdy;
    @(negedge clk);
  endtask
  initial begin
    cyc(0, SA, 0, 0);
    cyc(0, SA, 0, 0);
    check("rst_stat", stat_rd_data, 32'h0000_2000);
    check("rst_valid", {31'b0, node_valid}, 0);
    check("rst_done", {31'b0, path_done}, 0);
    check("rst_id", {27'b0, node_id}, 0);
    check("stat_hit", {31'b0, stat_hit}, 1);
    reset = 1'b1;
    cyc(1, PA, 3, 0);
    check("idle_to_load", stat_rd_data, 32'h0000_0101);
    cyc(1, PA, 7, 0);
    cyc(1, PA, 32'hFFFF_FFEC, 0);
    check("load3", stat_rd_data, 32'h0000_0103);
    check("load_novalid", {31'b0, node_valid}, 0);
    cyc(1, CA, 1, 0);
    check("run_valid", {31'b0, node_valid}, 1);
    check("id0", {27'b0, node_id}, 3);
    cyc(0, SA, 0, 1);
    check("id1", {27'b0, node_id}, 7);
    cyc(0, SA, 0, 1);
    check("id2", {27'b0, node_id}, 12);
    cyc(0, SA, 0, 1);
    check("done_stat", stat_rd_data, 32'h0000_2300);
    check("path_done", {31'b0, path_done}, 1);
    check("done_novalid", {31'b0, node_valid}, 0);
    cyc(1, PA, 5, 0);
    check("done_push_ignored", stat_rd_data, 32'h0000_2300);
    cyc(1, CA, 1, 0);
    check("done_to_idle", stat_rd_data, 32'h0000_2000);
    cyc(1, CA, 1, 0);
    check("idle_start_ignored", stat_rd_data, 32'h0000_2000);
    for (int i = 0; i < 17; i++) cyc(1, PA, i, 0);
    check("full_ovf", stat_rd_data, 32'h0000_5110);
    check("ovf_pin", {31'b0, overflow}, 1);
    cyc(1, CA, 1, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), {27'b0, node_id}, i);
      cyc(0, SA, 0, 1);
    end
    check("drain_done", stat_rd_data, 32'h0000_6300);
    cyc(1, CA, 2, 0);
    check("flush_done", stat_rd_data, 32'h0000_2000);
    cyc(1, PA, 5, 0);
    cyc(1, CA, 1, 0);
    check("run_cnt1", stat_rd_data, 32'h0000_0201);
    cyc(1, PA, 9, 1);
    check("pushpop_cnt", stat_rd_data, 32'h0000_0201);
    check("pushpop_id", {27'b0, node_id}, 9);
    for (int i = 0; i < 5; i++) begin
      cyc(0, SA, 0, 0);
      check($sformatf("hold_id%0d", i), {27'b0, node_id}, 9);
      check($sformatf("hold_cnt%0d", i), stat_rd_data, 32'h0000_0201);
    end
    for (int i = 0; i < 15; i++) cyc(1, PA, 11 + i, 0);
    check("run_full", stat_rd_data, 32'h0000_1210);
    cyc(1, PA, 30, 1);
    check("full_pushpop", stat_rd_data, 32'h0000_1210);
    check("full_pushpop_id", {27'b0, node_id}, 11);
    cyc(1, PA, 31, 0);
    check("run_ovf", stat_rd_data, 32'h0000_5210);
    cyc(1, CA, 3, 1);
    check("flush_run", stat_rd_data, 32'h0000_2000);
    check("flush_novalid", {31'b0, node_valid}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
